// File: rtl/md5_report_pkg.sv
// Shared types, ASCII constants and message helpers for the MD5 result reporter.
package md5_report_pkg;

  typedef enum logic [1:0] {MSG_NONE, MSG_FOUND, MSG_DONE, MSG_START} msg_t;
  typedef enum logic [1:0] {RPT_IDLE, RPT_LOAD, RPT_SEND, RPT_NEXT} rpt_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam logic [7:0] ASCII_F     = 8'h46;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_D     = 8'h44;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // "F:" plus eight hex digits
  localparam logic [3:0] FOUND_BODY_LEN = 4'd10;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
  endfunction

  function automatic logic [3:0] msg_len(input msg_t t, input logic crlf);
    logic [3:0] body;
    body = (t == MSG_FOUND) ? FOUND_BODY_LEN : 4'd1;
    return body + (crlf ? 4'd2 : 4'd1);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx_byte
  import md5_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       CPU_RESETN,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state, state_n;
  logic [15:0] clk_cnt, clk_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state   <= TX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

  // Handshake: start is honoured only while ready (idle); byte_done is high
  // for exactly the last clock of the stop bit, after which ready returns.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + 16'd1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx;
    byte_done = 1'b0;
    ready     = (state == TX_IDLE);
    case (state)
      TX_IDLE: begin
        clk_cnt_n = '0;
        tx_n      = 1'b1;
        if (start) begin
          shreg_n = data;
          state_n = TX_START;
          tx_n    = 1'b0;
        end
      end
      TX_START: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          tx_n      = shreg[0];
          state_n   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = TX_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end
      TX_STOP: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_n = '0;
          byte_done = 1'b1;
          state_n   = TX_IDLE;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/md5_result_reporter.sv
// Watches the MD5 driver status lines and reports found/done/start events as ASCII over UART.
module md5_result_reporter
  import md5_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit NEWLINE_CRLF = 1'b1
) (
  input  logic        CLK,
  input  logic        CPU_RESETN,
  input  logic [31:0] target,
  input  logic        status_found,
  input  logic        status_done,
  input  logic        enabled,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  report_count,
  output logic        overflow,
  output rpt_state_t  dbg_state
);

  logic        prev_found, prev_done, prev_en;
  logic        found_evt, done_evt, start_evt;
  msg_t        evt_type, act_type, pend_type;
  logic [31:0] evt_val, act_val, pend_val;
  logic        pend_valid;
  rpt_state_t  state, state_n;
  logic [3:0]  byte_idx, idx_n, last_idx, body_len;
  logic [3:0]  nib;
  logic [7:0]  tx_byte;
  logic        tx_start, tx_ready, byte_done, finish;

  assign found_evt = status_found & ~prev_found;
  assign done_evt  = status_done & ~prev_done;
  assign start_evt = enabled & ~prev_en;
  assign evt_type  = found_evt ? MSG_FOUND : done_evt ? MSG_DONE : start_evt ? MSG_START : MSG_NONE;
  assign evt_val   = found_evt ? target : '0;
  assign last_idx  = msg_len(act_type, NEWLINE_CRLF) - 4'd1;
  assign busy      = (state != RPT_IDLE) | pend_valid;
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= RPT_IDLE;
      byte_idx <= '0;
    end else begin
      state    <= state_n;
      byte_idx <= idx_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = byte_idx;
    tx_start = 1'b0;
    finish   = 1'b0;
    case (state)
      RPT_IDLE: if (evt_type != MSG_NONE) begin
        state_n = RPT_LOAD;
        idx_n   = '0;
      end
      RPT_LOAD: begin
        tx_start = tx_ready;
        state_n  = RPT_SEND;
      end
      RPT_SEND: if (byte_done) state_n = RPT_NEXT;
      RPT_NEXT: begin
        if (byte_idx == last_idx) begin
          finish  = 1'b1;
          idx_n   = '0;
          // chain straight into the next message when one is waiting
          state_n = (pend_valid || evt_type != MSG_NONE) ? RPT_LOAD : RPT_IDLE;
        end else begin
          idx_n   = byte_idx + 4'd1;
          state_n = RPT_LOAD;
        end
      end
      default: state_n = RPT_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      prev_found   <= 1'b0;
      prev_done    <= 1'b0;
      prev_en      <= 1'b0;
      act_type     <= MSG_NONE;
      act_val      <= '0;
      pend_type    <= MSG_NONE;
      pend_val     <= '0;
      pend_valid   <= 1'b0;
      report_count <= '0;
      overflow     <= 1'b0;
    end else begin
      prev_found <= status_found;
      prev_done  <= status_done;
      prev_en    <= enabled;
      if (state == RPT_IDLE) begin
        if (evt_type != MSG_NONE) begin
          act_type <= evt_type;
          act_val  <= evt_val;
        end
      end else if (finish) begin
        if (pend_valid) begin
          act_type   <= pend_type;
          act_val    <= pend_val;
          pend_valid <= (evt_type != MSG_NONE);
          if (evt_type != MSG_NONE) begin
            pend_type <= evt_type;
            pend_val  <= evt_val;
          end
        end else if (evt_type != MSG_NONE) begin
          act_type <= evt_type;
          act_val  <= evt_val;
        end
      end else if (evt_type != MSG_NONE) begin
        if (!pend_valid) begin
          pend_type  <= evt_type;
          pend_val   <= evt_val;
          pend_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (finish) report_count <= report_count + 8'd1;
    end
  end

  always_comb begin
    case (byte_idx)
      4'd2:    nib = act_val[31:28];
      4'd3:    nib = act_val[27:24];
      4'd4:    nib = act_val[23:20];
      4'd5:    nib = act_val[19:16];
      4'd6:    nib = act_val[15:12];
      4'd7:    nib = act_val[11:8];
      4'd8:    nib = act_val[7:4];
      4'd9:    nib = act_val[3:0];
      default: nib = 4'h0;
    endcase
  end

  // Byte layout: body (F: + hex, or a single letter), then CR (optional) and LF.
  always_comb begin
    body_len = (act_type == MSG_FOUND) ? FOUND_BODY_LEN : 4'd1;
    tx_byte  = ASCII_LF;
    if (byte_idx < body_len) begin
      if (act_type == MSG_FOUND) begin
        if (byte_idx == 4'd0)      tx_byte = ASCII_F;
        else if (byte_idx == 4'd1) tx_byte = ASCII_COLON;
        else                       tx_byte = hex_ascii(nib);
      end else begin
        tx_byte = (act_type == MSG_DONE) ? ASCII_D : ASCII_S;
      end
    end else if (NEWLINE_CRLF && byte_idx == body_len) begin
      tx_byte = ASCII_CR;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .CLK       (CLK),
    .CPU_RESETN(CPU_RESETN),
    .data      (tx_byte),
    .start     (tx_start),
    .tx        (uart_tx),
    .ready     (tx_ready),
    .byte_done (byte_done)
  );

endmodule
